// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus responder: FSM state encoding,
// default widths and the bus-level constants initiators rely on.
package sram_bus_pkg;

    localparam int   DEF_DATA_W = 16;
    localparam int   DEF_ADDR_W = 11;
    // Cycles from the accept edge until read data is valid on the bus.
    localparam int   READ_LAT   = 2;
    // WrEn level that requests a write (active low).
    localparam logic WREN_WRITE = 1'b0;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WACK,
        RFETCH,
        RDATA,
        TURN
    } state_e;

endpackage

// File: rtl/sram_resp_array.sv
// Single-port storage array: synchronous write, registered read.
// Accesses are serialized by the owning FSM, so read-during-write
// ordering never matters.
module sram_resp_array #(
    parameter int DATA_W = 16,
    parameter int AW     = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_bus_responder.sv
// Memory-side responder for the shared-bus SRAM interface. Adds a
// req/ack handshake, a one-cycle bus turnaround after reads, a zero-fill
// sweep and out-of-range error reporting on top of a plain array.
//
// Handshake: the initiator raises req (with WrEn, adx and, for writes,
// data) and it is sampled only while IDLE; ack is a one-cycle pulse
// (write: one cycle after accept, read: two cycles after accept with
// data valid on the bus in that same cycle); err reflects the ack'd
// access and holds until the next ack. The bus is driven only in RDATA.
module sram_bus_responder
    import sram_bus_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = 2048,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] adx,
    inout  tri   [DATA_W-1:0] data,
    input  logic              clrReq,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output state_e            state_dbg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Addresses are compared zero-extended so DEPTH = 2**ADDR_W fits.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_WORD = AW'(DEPTH - 1);

    state_e            state, state_nxt;
    logic [AW-1:0]     clr_cnt;
    logic [ADDR_W-1:0] adx_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              oor;
    logic              drive_en;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign oor = {1'b0, adx_q} >= DEPTH_EXT;

    // State register; reset restarts the sweep or lands in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RST ? INIT : IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request sampling, clear counter and sticky error status.
    always_ff @(posedge clk) begin
        if (rst) begin
            adx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            clr_cnt <= '0;
        end else begin
            if (state == IDLE && !clrReq && req) begin
                adx_q <= adx;
                wr_q  <= WrEn;
                if (WrEn == WREN_WRITE) begin
                    wdata_q <= data;
                end
            end
            if (state == IDLE && clrReq) begin
                clr_cnt <= '0;
            end else if (state == INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (ack) begin
                err_q <= oor;
            end
        end
    end

    // Next-state decode plus array control and handshake outputs.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        drive_en  = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = adx_q[AW-1:0];
        arr_wdata = wdata_q;
        case (state)
            INIT: begin
                arr_we    = 1'b1;
                arr_addr  = clr_cnt;
                arr_wdata = '0;
                if (clr_cnt == LAST_WORD) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clrReq) begin
                    state_nxt = INIT;
                end else if (req) begin
                    state_nxt = (WrEn == WREN_WRITE) ? WACK : RFETCH;
                end
            end
            WACK: begin
                ack       = 1'b1;
                arr_we    = (wr_q == WREN_WRITE) && !oor;
                state_nxt = IDLE;
            end
            RFETCH: begin
                state_nxt = RDATA;
            end
            RDATA: begin
                ack       = 1'b1;
                drive_en  = 1'b1;
                state_nxt = TURN;
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign err       = ack ? oor : err_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign data      = drive_en ? (oor ? '0 : arr_rdata) : {DATA_W{1'bz}};

    sram_resp_array #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder. Unit 0 is the full 2048-word
// part, unit 1 a 1024-word part with 11-bit addresses so out-of-range
// handling can be exercised. Both buses have pull-ups, so a released
// bus reads 0xFFFF.
module tb_sram_bus_responder;
    import sram_bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, wren_a, clr_a, ack_a, err_a, busy_a;
    logic        rst_b, req_b, wren_b, clr_b, ack_b, err_b, busy_b;
    logic [10:0] adx_a, adx_b;
    state_e      st_a, st_b;
    tri1  [15:0] data_a, data_b;
    logic        drv_en_a, drv_en_b;
    logic [15:0] drv_val_a, drv_val_b;

    assign data_a = drv_en_a ? drv_val_a : 16'bz;
    assign data_b = drv_en_b ? drv_val_b : 16'bz;

    sram_bus_responder #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .CLEAR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .WrEn(wren_a), .adx(adx_a), .data(data_a),
        .clrReq(clr_a), .ack(ack_a), .err(err_a), .busy(busy_a), .state_dbg(st_a)
    );

    sram_bus_responder #(.DATA_W(16), .ADDR_W(11), .DEPTH(1024), .CLEAR_ON_RST(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .WrEn(wren_b), .adx(adx_b), .data(data_b),
        .clrReq(clr_b), .ack(ack_b), .err(err_b), .busy(busy_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_ack(int u);
        return (u == 0) ? 32'(ack_a) : 32'(ack_b);
    endfunction
    function automatic logic [31:0] get_err(int u);
        return (u == 0) ? 32'(err_a) : 32'(err_b);
    endfunction
    function automatic logic [31:0] get_busy(int u);
        return (u == 0) ? 32'(busy_a) : 32'(busy_b);
    endfunction
    function automatic logic [31:0] get_bus(int u);
        return (u == 0) ? 32'(data_a) : 32'(data_b);
    endfunction
    function automatic logic [31:0] get_st(int u);
        return (u == 0) ? 32'(st_a) : 32'(st_b);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(int u, logic r, logic w, logic [10:0] a);
        if (u == 0) begin
            req_a = r; wren_a = w; adx_a = a;
        end else begin
            req_b = r; wren_b = w; adx_b = a;
        end
    endtask

    task automatic set_drv(int u, logic en, logic [15:0] v);
        if (u == 0) begin
            drv_en_a = en; drv_val_a = v;
        end else begin
            drv_en_b = en; drv_val_b = v;
        end
    endtask

    // Called at a negedge with the unit IDLE; returns at a negedge, IDLE.
    task automatic do_write(int u, logic [10:0] a, logic [15:0] d, logic exp_err, string tag);
        set_in(u, 1'b1, 1'b0, a);
        set_drv(u, 1'b1, d);
        @(negedge clk);
        chk({tag, " wack ack"}, get_ack(u), 32'd1);
        chk({tag, " wack err"}, get_err(u), 32'(exp_err));
        chk({tag, " wack state"}, get_st(u), 32'(WACK));
        set_in(u, 1'b0, 1'b1, a);
        set_drv(u, 1'b0, 16'h0000);
        #1;
        chk({tag, " wack bus released"}, get_bus(u), 32'hFFFF);
        @(negedge clk);
        chk({tag, " idle ack"}, get_ack(u), 32'd0);
        chk({tag, " idle busy"}, get_busy(u), 32'd0);
        chk({tag, " err hold"}, get_err(u), 32'(exp_err));
    endtask

    // Read with a probe request raised during TURN that must be ignored.
    task automatic do_read(int u, logic [10:0] a, logic [15:0] exp_d, logic exp_err, string tag);
        set_in(u, 1'b1, 1'b1, a);
        @(negedge clk);
        chk({tag, " rfetch ack"}, get_ack(u), 32'd0);
        chk({tag, " rfetch bus"}, get_bus(u), 32'hFFFF);
        chk({tag, " rfetch busy"}, get_busy(u), 32'd1);
        set_in(u, 1'b0, 1'b1, a);
        @(negedge clk);
        chk({tag, " rdata ack"}, get_ack(u), 32'd1);
        chk({tag, " rdata data"}, get_bus(u), 32'(exp_d));
        chk({tag, " rdata err"}, get_err(u), 32'(exp_err));
        chk({tag, " rdata state"}, get_st(u), 32'(RDATA));
        @(negedge clk);
        chk({tag, " turn ack"}, get_ack(u), 32'd0);
        chk({tag, " turn bus"}, get_bus(u), 32'hFFFF);
        chk({tag, " turn err hold"}, get_err(u), 32'(exp_err));
        set_in(u, 1'b1, 1'b1, ~a);
        @(negedge clk);
        chk({tag, " turn probe ignored"}, get_busy(u), 32'd0);
        chk({tag, " idle ack"}, get_ack(u), 32'd0);
        set_in(u, 1'b0, 1'b1, a);
    endtask

    // Counts busy cycles starting with the current one.
    task automatic count_busy(int u, int bound, output int cnt, output logic ack_seen);
        cnt      = 0;
        ack_seen = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (get_busy(u) == 32'd0) break;
            cnt++;
            if (get_ack(u) != 32'd0) ack_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   cnt_a, cnt_b, cnt;
        logic ack_seen;

        rst_a = 1'b1; rst_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        set_in(0, 1'b0, 1'b1, 11'h000);
        set_in(1, 1'b0, 1'b1, 11'h000);
        set_drv(0, 1'b0, 16'h0000);
        set_drv(1, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);

        chk("reset busy a", get_busy(0), 32'd1);
        chk("reset busy b", get_busy(1), 32'd1);
        chk("reset ack a", get_ack(0), 32'd0);
        chk("reset err a", get_err(0), 32'd0);
        chk("reset bus a", get_bus(0), 32'hFFFF);
        chk("reset state a", get_st(0), 32'(INIT));
        rst_a = 1'b0; rst_b = 1'b0;

        // Both sweeps together; req and clrReq poked mid-sweep must be ignored.
        cnt_a = 0; cnt_b = 0; ack_seen = 1'b0;
        for (int c = 0; c < 2300; c++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (ack_a || ack_b) ack_seen = 1'b1;
            if (!busy_a && !busy_b) break;
            if (c == 10) begin
                set_in(0, 1'b1, 1'b1, 11'h010);
                set_in(1, 1'b1, 1'b0, 11'h010);
            end
            if (c == 20) begin
                clr_a = 1'b1; clr_b = 1'b1;
            end
            if (c == 21) begin
                clr_a = 1'b0; clr_b = 1'b0;
            end
            if (c == 100) begin
                set_in(0, 1'b0, 1'b1, 11'h000);
                set_in(1, 1'b0, 1'b1, 11'h000);
            end
            @(negedge clk);
        end
        chk("sweep cycles a", 32'(cnt_a), 32'd2048);
        chk("sweep cycles b", 32'(cnt_b), 32'd1024);
        chk("sweep no ack", 32'(ack_seen), 32'd0);

        do_read(0, 11'h000, 16'h0000, 1'b0, "clr rd 000");
        do_read(0, 11'h3FF, 16'h0000, 1'b0, "clr rd 3ff");
        do_read(0, 11'h7FF, 16'h0000, 1'b0, "clr rd 7ff");

        do_write(0, 11'h07F, 16'h00A5, 1'b0, "wr 07f");
        do_read(0, 11'h07F, 16'h00A5, 1'b0, "rd 07f");

        // Back-to-back writes then reads, expected values queued.
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(16'(32'h7F - i));
            do_write(0, 11'(i), 16'(32'h7F - i), 1'b0, "b2b wr");
        end
        for (int i = 0; i < 32; i++) begin
            do_read(0, 11'(i), exp_q.pop_front(), 1'b0, "b2b rd");
        end
        do_read(0, 11'h07F, 16'h00A5, 1'b0, "rd 07f again");

        // Top word of a full-depth part is in range.
        do_write(0, 11'h7FF, 16'h1357, 1'b0, "wr 7ff");
        do_read(0, 11'h7FF, 16'h1357, 1'b0, "rd 7ff");

        // Out-of-range on the 1024-word part; 0x500 aliases 0x100 in the array.
        do_write(1, 11'h500, 16'hBEEF, 1'b1, "oor wr 500");
        do_read(1, 11'h500, 16'h0000, 1'b1, "oor rd 500");
        do_read(1, 11'h100, 16'h0000, 1'b0, "alias rd 100");

        do_write(1, 11'h123, 16'h1234, 1'b0, "wr 123");
        do_write(1, 11'h3FF, 16'hCAFE, 1'b0, "wr 3ff");
        do_read(1, 11'h123, 16'h1234, 1'b0, "rd 123");
        do_read(1, 11'h3FF, 16'hCAFE, 1'b0, "rd 3ff");

        // clrReq and req together: clear wins, no ack.
        clr_b = 1'b1;
        set_in(1, 1'b1, 1'b1, 11'h123);
        @(negedge clk);
        chk("clr+req state", get_st(1), 32'(INIT));
        chk("clr+req ack", get_ack(1), 32'd0);
        clr_b = 1'b0;
        set_in(1, 1'b0, 1'b1, 11'h000);
        count_busy(1, 1200, cnt, ack_seen);
        chk("clr sweep cycles", 32'(cnt), 32'd1024);
        chk("clr sweep no ack", 32'(ack_seen), 32'd0);
        do_read(1, 11'h123, 16'h0000, 1'b0, "post clr rd 123");
        do_read(1, 11'h3FF, 16'h0000, 1'b0, "post clr rd 3ff");

        // Reset in the middle of an out-of-range read's RDATA cycle.
        do_write(1, 11'h010, 16'hABCD, 1'b0, "wr 010");
        set_in(1, 1'b1, 1'b1, 11'h700);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1, 11'h000);
        @(negedge clk);
        chk("pre-rst rdata ack", get_ack(1), 32'd1);
        chk("pre-rst rdata err", get_err(1), 32'd1);
        chk("pre-rst rdata data", get_bus(1), 32'h0000);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst mid-read ack", get_ack(1), 32'd0);
        chk("rst mid-read bus", get_bus(1), 32'hFFFF);
        chk("rst mid-read err", get_err(1), 32'd0);
        chk("rst mid-read state", get_st(1), 32'(INIT));
        rst_b = 1'b0;
        count_busy(1, 1200, cnt, ack_seen);
        chk("rst sweep cycles", 32'(cnt), 32'd1024);
        chk("rst sweep no ack", 32'(ack_seen), 32'd0);
        do_read(1, 11'h010, 16'h0000, 1'b0, "post rst rd 010");

        // Read latency sanity against the package constant.
        chk("read latency const", 32'(READ_LAT), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
